// File: rtl/armaria_io_pkg.sv
// Shared definitions for the Armaria IO input path: FSM encoding,
// default switch word width and the confirm button's active level.
package armaria_io_pkg;

  typedef enum logic [1:0] {
    ST_IDLE         = 2'b00,
    ST_WAIT_RELEASE = 2'b01,
    ST_WAIT_PRESS   = 2'b10,
    ST_ACK          = 2'b11
  } cap_state_t;

  localparam int DEFAULT_DATA_W = 16;

  // confirm_n reads 0 while the button is held down
  localparam logic BTN_ACTIVE = 1'b0;

endpackage

// File: rtl/debounce_bit.sv
// Two-flop synchroniser followed by a 3-sample debounce history for a
// bundle of WIDTH independent bits. Samples advance on the shared tick;
// a debounced bit changes only when its three samples agree.
module debounce_bit #(
  parameter int   WIDTH     = 1,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             tick,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] sync1, sync2;
  logic [WIDTH-1:0] h0, h1, h2;
  logic [WIDTH-1:0] agree;

  // bring the asynchronous levels into the clock domain
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1 <= {WIDTH{RESET_VAL}};
      sync2 <= {WIDTH{RESET_VAL}};
    end else begin
      sync1 <= din;
      sync2 <= sync1;
    end
  end

  // sample history advances once per tick
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      h0 <= {WIDTH{RESET_VAL}};
      h1 <= {WIDTH{RESET_VAL}};
      h2 <= {WIDTH{RESET_VAL}};
    end else if (tick) begin
      h0 <= sync2;
      h1 <= h0;
      h2 <= h1;
    end
  end

  assign agree = ~(h0 ^ h1) & ~(h1 ^ h2);

  // each bit follows its history only where all three samples agree
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      dout <= {WIDTH{RESET_VAL}};
    end else begin
      dout <= (agree & h0) | (~agree & dout);
    end
  end

endmodule

// File: rtl/switch_input_capture.sv
// Switch input capture for the IO module: debounces the board switches and
// the confirm button, and on a request latches the switch word when the
// user makes a fresh confirm press.
// Optional macro ARMARIA_INPUT_TIMEOUT_EN adds a forced capture after
// TIMEOUT_TICKS debounce ticks of waiting.
//
//   state           | meaning
//   ----------------+------------------------------------------------
//   ST_IDLE         | no request pending
//   ST_WAIT_RELEASE | request pending, button still held from before
//   ST_WAIT_PRESS   | request pending, waiting for a new press
//   ST_ACK          | capture done, ack (and maybe timeout) pulse
module switch_input_capture
  import armaria_io_pkg::*;
#(
  parameter int DATA_W          = DEFAULT_DATA_W,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int TIMEOUT_TICKS   = 5000
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [DATA_W-1:0] sw,
  input  logic              confirm_n,
  input  logic              req,
  output logic [DATA_W-1:0] data_out,
  output logic              ack,
  output logic              waiting,
  output logic              timeout
);

  localparam int PW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic [PW-1:0]     presc;
  logic              tick;
  logic [DATA_W-1:0] db_sw;
  logic              db_confirm_n;
  logic              pressed;
  logic              pressed_d;
  logic              press_edge;
  logic              tmo_hit;
  logic              forced_q;
  cap_state_t        state, state_nxt;
  logic              capture;
  logic              forced;

  assign tick = (presc == PW'(DEBOUNCE_CYCLES - 1));

  // free-running sample-tick prescaler
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      presc <= '0;
    end else if (tick) begin
      presc <= '0;
    end else begin
      presc <= presc + 1'b1;
    end
  end

  debounce_bit #(.WIDTH(DATA_W), .RESET_VAL(1'b0)) u_db_sw (
    .clock (clock),
    .reset (reset),
    .tick  (tick),
    .din   (sw),
    .dout  (db_sw)
  );

  // released level is the opposite of the active level
  debounce_bit #(.WIDTH(1), .RESET_VAL(~BTN_ACTIVE)) u_db_confirm (
    .clock (clock),
    .reset (reset),
    .tick  (tick),
    .din   (confirm_n),
    .dout  (db_confirm_n)
  );

  assign pressed    = (db_confirm_n == BTN_ACTIVE);
  assign press_edge = pressed & ~pressed_d;

  // previous debounced press level for edge detection
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pressed_d <= 1'b0;
    end else begin
      pressed_d <= pressed;
    end
  end

`ifdef ARMARIA_INPUT_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_TICKS + 1);
  logic [TW-1:0] tcnt;

  assign tmo_hit = (tcnt == TW'(TIMEOUT_TICKS));

  // counts ticks while a request is pending; cleared outside the wait states
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      tcnt <= '0;
    end else if (!waiting) begin
      tcnt <= '0;
    end else if (tick && !tmo_hit) begin
      tcnt <= tcnt + 1'b1;
    end
  end
`else
  logic unused_timeout_ticks;
  assign unused_timeout_ticks = (TIMEOUT_TICKS > 0);
  assign tmo_hit = 1'b0;
`endif

  // state register, capture latch and forced-capture flag
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= ST_IDLE;
      data_out <= '0;
      forced_q <= 1'b0;
    end else begin
      state <= state_nxt;
      if (capture) begin
        data_out <= db_sw;
        forced_q <= forced;
      end
    end
  end

  // next-state decode; a press in the timeout cycle counts as a press
  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    forced    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (req) state_nxt = pressed ? ST_WAIT_RELEASE : ST_WAIT_PRESS;
      end
      ST_WAIT_RELEASE: begin
        if (tmo_hit) begin
          capture   = 1'b1;
          forced    = 1'b1;
          state_nxt = ST_ACK;
        end else if (!pressed) begin
          state_nxt = ST_WAIT_PRESS;
        end
      end
      ST_WAIT_PRESS: begin
        if (press_edge) begin
          capture   = 1'b1;
          state_nxt = ST_ACK;
        end else if (tmo_hit) begin
          capture   = 1'b1;
          forced    = 1'b1;
          state_nxt = ST_ACK;
        end
      end
      ST_ACK: begin
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign waiting = (state == ST_WAIT_RELEASE) || (state == ST_WAIT_PRESS);
  assign ack     = (state == ST_ACK);
  assign timeout = ack & forced_q;

endmodule
